// File: rtl/ll_rlp_arb.sv
// Round-robin arbiter sharing the link list manager's rlp/rlpr interfaces among write ports.
// Optional LLRLP_ARB_REGOUT_EN drives rlp from a 2-entry skid register instead of combinationally.
module ll_rlp_arb #(
   parameter int unsigned lpsz      = 8,
   parameter int unsigned lpdsz     = lpsz + 1,
   parameter int unsigned ports     = 4,
   parameter int unsigned tag_depth = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ports-1:0]                req_srdy,
   output logic [ports-1:0]                req_drdy,
   input  logic [ports*lpsz-1:0]           req_page,
   output logic [ports-1:0]                rsp_srdy,
   input  logic [ports-1:0]                rsp_drdy,
   output logic [lpdsz-1:0]                rsp_data,
   output logic                            rlp_srdy,
   input  logic                            rlp_drdy,
   output logic [lpsz-1:0]                 rlp_rd_page,
   input  logic                            rlpr_srdy,
   output logic                            rlpr_drdy,
   input  logic [lpdsz-1:0]                rlpr_data,
   output logic [$clog2(tag_depth+1)-1:0]  outstanding,
   output logic                            err_orphan
);

   localparam int unsigned PW = (ports > 1) ? $clog2(ports) : 1;
   localparam int unsigned AW = $clog2(tag_depth);
   localparam int unsigned CW = $clog2(tag_depth + 1);

   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_gnt;
   logic [PW-1:0]   w_idx;
   logic            w_any;
   logic [lpsz-1:0] w_page;
   logic            w_rdy;
   logic            w_accept;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [PW-1:0]   w_head;
   logic [PW-1:0]   r_tag [tag_depth];
   logic [AW-1:0]   r_wp;
   logic [AW-1:0]   r_rp;
   logic [CW-1:0]   r_cnt;
   logic            r_err;

   assign w_full  = (r_cnt == CW'(tag_depth));
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_tag[r_rp];

   // first requesting port at or above the priority pointer, wrapping
   always_comb begin
      w_gnt = r_ptr;
      w_any = 1'b0;
      w_idx = '0;
      for (int unsigned k = 0; k < ports; k++) begin
         w_idx = PW'((32'(r_ptr) + k) % ports);
         if (!w_any && req_srdy[w_idx]) begin
            w_any = 1'b1;
            w_gnt = w_idx;
         end
      end
   end

   assign w_page   = req_page[32'(w_gnt)*lpsz +: lpsz];
   assign w_accept = w_any & w_rdy;

`ifdef LLRLP_ARB_REGOUT_EN
   logic            r_out_vld;
   logic [lpsz-1:0] r_out_page;
   logic            r_hold_vld;
   logic [lpsz-1:0] r_hold_page;
   logic            w_out_free;

   // skid accepts only while the hold slot is empty, so the ready never looks at rlp_drdy
   assign w_rdy       = !w_full & !r_hold_vld & !reset;
   assign w_out_free  = !r_out_vld | rlp_drdy;
   assign rlp_srdy    = r_out_vld & !reset;
   assign rlp_rd_page = r_out_page;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_vld  <= 1'b0;
         r_hold_vld <= 1'b0;
      end else if (w_out_free) begin
         if (r_hold_vld) begin
            r_out_vld   <= 1'b1;
            r_out_page  <= r_hold_page;
            r_hold_vld  <= w_accept;
            r_hold_page <= w_page;
         end else begin
            r_out_vld  <= w_accept;
            r_out_page <= w_page;
         end
      end else if (w_accept) begin
         r_hold_vld  <= 1'b1;
         r_hold_page <= w_page;
      end
   end
`else
   assign w_rdy       = rlp_drdy & !w_full & !reset;
   assign rlp_srdy    = w_any & !w_full & !reset;
   assign rlp_rd_page = w_page;
`endif

   always_comb begin
      req_drdy        = '0;
      req_drdy[w_gnt] = w_accept;
   end

   // responses return in request order; the FIFO head names the destination port
   always_comb begin
      rsp_srdy = '0;
      if (!w_empty && !reset) rsp_srdy[w_head] = rlpr_srdy;
   end

   assign rlpr_drdy   = rsp_drdy[w_head] & !w_empty & !reset;
   assign rsp_data    = rlpr_data;
   assign w_pop       = rlpr_srdy & rlpr_drdy;
   assign outstanding = r_cnt;
   assign err_orphan  = r_err;

   always_ff @(posedge clk) begin
      if (w_accept) r_tag[r_wp] <= w_gnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wp  <= r_wp + 1'b1;
            r_ptr <= PW'((32'(w_gnt) + 1) % ports);
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (rlpr_srdy && w_empty) r_err <= 1'b1;
      end
   end

endmodule
